// File: rtl/cache_ctrl_pkg.sv
// Shared state and operation encodings for the data-cache maintenance controllers.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WB,
    DONE
  } flush_state_t;

  typedef enum logic {
    OP_CLEAR,
    OP_FLUSH
  } flush_op_t;

endpackage

// File: rtl/dcache_flush_ctrl.sv
// Walks every cache line to write back dirty lines (flush) and/or invalidate them (clear).
// Optional writeback counter output enabled by defining DCACHE_FLUSH_WB_COUNT_EN.
module dcache_flush_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int ASSOC    = 2,
  localparam int IDX_W   = $clog2(NUM_SETS * ASSOC)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dcache_flush,
  input  logic             dcache_clear,
  output logic             dflush_done,
  output logic             dclear_done,
  output logic [IDX_W-1:0] line_idx,
  input  logic             line_valid,
  input  logic             line_dirty,
  output logic             wb_req,
  input  logic             wb_ack,
  output logic             line_inv,
  output logic             busy
`ifdef DCACHE_FLUSH_WB_COUNT_EN
  ,
  output logic [15:0]      wb_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS * ASSOC - 1);

  flush_state_t     state_reg;
  flush_op_t        op_reg;
  logic [IDX_W-1:0] idx_reg;

  logic needs_wb;
  logic op_req;
  logic at_last;
  logic start;

  assign needs_wb = (op_reg == OP_FLUSH) && line_valid && line_dirty;
  assign op_req   = (op_reg == OP_FLUSH) ? dcache_flush : dcache_clear;
  assign at_last  = (idx_reg == LAST_IDX);
  assign start    = (state_reg == IDLE) && (dcache_flush || dcache_clear);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
      op_reg    <= OP_CLEAR;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg    <= dcache_flush ? OP_FLUSH : OP_CLEAR;
            idx_reg   <= '0;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          if (needs_wb) begin
            state_reg <= WB;
          end else if (at_last) begin
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        WB: begin
          if (wb_ack) begin
            if (at_last) begin
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= SCAN;
            end
          end
        end
        DONE: begin
          if (!op_req) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; line_inv also folds in the same-cycle ack.
  assign line_idx    = idx_reg;
  assign busy        = (state_reg == SCAN) || (state_reg == WB);
  assign wb_req      = (state_reg == WB);
  assign line_inv    = ((state_reg == SCAN) && !needs_wb) || ((state_reg == WB) && wb_ack);
  assign dflush_done = (state_reg == DONE) && (op_reg == OP_FLUSH);
  assign dclear_done = (state_reg == DONE);

`ifdef DCACHE_FLUSH_WB_COUNT_EN
  logic [15:0] wb_count_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_count_reg <= '0;
    end else if (start) begin
      wb_count_reg <= '0;
    end else if ((state_reg == WB) && wb_ack && (wb_count_reg != 16'hFFFF)) begin
      wb_count_reg <= wb_count_reg + 16'd1;
    end
  end

  assign wb_count = wb_count_reg;
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl with 4 sets x 2 ways (8 lines).
module tb_dcache_flush_ctrl;

  logic       CLK;
  logic       nRST;
  logic       dcache_flush;
  logic       dcache_clear;
  logic       dflush_done;
  logic       dclear_done;
  logic [2:0] line_idx;
  logic       line_valid;
  logic       line_dirty;
  logic       wb_req;
  logic       wb_ack;
  logic       line_inv;
  logic       busy;
`ifdef DCACHE_FLUSH_WB_COUNT_EN
  logic [15:0] wb_count;
`endif

  logic [7:0] valid_mask;
  logic [7:0] dirty_mask;
  int errors;
  int checks;

  assign line_valid = valid_mask[line_idx];
  assign line_dirty = dirty_mask[line_idx];

  dcache_flush_ctrl #(.NUM_SETS(4), .ASSOC(2)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .dcache_flush(dcache_flush),
    .dcache_clear(dcache_clear),
    .dflush_done(dflush_done),
    .dclear_done(dclear_done),
    .line_idx(line_idx),
    .line_valid(line_valid),
    .line_dirty(line_dirty),
    .wb_req(wb_req),
    .wb_ack(wb_ack),
    .line_inv(line_inv),
    .busy(busy)
`ifdef DCACHE_FLUSH_WB_COUNT_EN
    ,
    .wb_count(wb_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic step();
    @(negedge CLK);
    wb_ack = 1'b0;
    #1;
  endtask

  // Expected per-line sequence: a dirty valid line under flush costs one SCAN
  // cycle without invalidate, ack_dly WB cycles, then an ack cycle that invalidates.
  task automatic do_walk(input bit is_flush, input int ack_dly, input int drop_at, input int stray_at);
    for (int i = 0; i < 8; i++) begin
      if (drop_at == i) begin
        dcache_flush = 1'b0;
        dcache_clear = 1'b0;
      end
      chk($sformatf("idx_%0d", i), line_idx, i);
      chk($sformatf("busy_%0d", i), busy, 1);
      if (is_flush && valid_mask[i] && dirty_mask[i]) begin
        chk($sformatf("scan_noinv_%0d", i), line_inv, 0);
        chk($sformatf("scan_nowb_%0d", i), wb_req, 0);
        step();
        for (int d = 0; d < ack_dly; d++) begin
          chk($sformatf("wb_req_%0d", i), wb_req, 1);
          chk($sformatf("wb_noinv_%0d", i), line_inv, 0);
          chk($sformatf("wb_idx_%0d", i), line_idx, i);
          step();
        end
        wb_ack = 1'b1;
        #1;
        chk($sformatf("ack_req_%0d", i), wb_req, 1);
        chk($sformatf("ack_inv_%0d", i), line_inv, 1);
        step();
      end else begin
        if (stray_at == i) begin
          wb_ack = 1'b1;
          #1;
        end
        chk($sformatf("scan_inv_%0d", i), line_inv, 1);
        chk($sformatf("scan_wb_%0d", i), wb_req, 0);
        step();
      end
    end
  endtask

  task automatic start_req(input bit f, input bit c);
    dcache_flush = f;
    dcache_clear = c;
    #1;
    chk("start_idle_busy", busy, 0);
    chk("start_idle_inv", line_inv, 0);
    step();
  endtask

  task automatic check_done_held(input bit exp_fd);
    chk("done_flush", dflush_done, exp_fd);
    chk("done_clear", dclear_done, 1);
    chk("done_busy", busy, 0);
    chk("done_inv", line_inv, 0);
    step();
    chk("done_hold_clear", dclear_done, 1);
    dcache_flush = 1'b0;
    dcache_clear = 1'b0;
    step();
    chk("idle_flush_done", dflush_done, 0);
    chk("idle_clear_done", dclear_done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    nRST         = 1'b0;
    dcache_flush = 1'b0;
    dcache_clear = 1'b0;
    wb_ack       = 1'b0;
    valid_mask   = 8'hFF;
    dirty_mask   = 8'hFF;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wb_req", wb_req, 0);
    chk("rst_line_inv", line_inv, 0);
    chk("rst_dflush_done", dflush_done, 0);
    chk("rst_dclear_done", dclear_done, 0);
    chk("rst_idx", line_idx, 0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;

    // Stray ack while idle must not start anything.
    wb_ack = 1'b1;
    #1;
    chk("stray_idle_inv", line_inv, 0);
    step();
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_idx", line_idx, 0);

    // Clear of all-dirty lines: no writebacks, stray ack at idx 2 ignored.
    start_req(1'b0, 1'b1);
    do_walk(1'b0, 0, -1, 2);
    check_done_held(1'b0);

    // Flush with lines 2 and 5 dirty, ack 3 cycles after wb_req.
    dirty_mask = 8'b0010_0100;
    start_req(1'b1, 1'b0);
    do_walk(1'b1, 3, -1, -1);
`ifdef DCACHE_FLUSH_WB_COUNT_EN
    chk("wb_count_flush", wb_count, 2);
`endif
    check_done_held(1'b1);

    // Both requests: flush wins; first and last line dirty, line 5 dirty but invalid.
    valid_mask = 8'b1101_1111;
    dirty_mask = 8'b1010_0001;
    start_req(1'b1, 1'b1);
    do_walk(1'b1, 0, -1, -1);
    check_done_held(1'b1);

    // Request dropped at idx 3: walk completes, DONE for one cycle, then IDLE.
    valid_mask = 8'hFF;
    dirty_mask = 8'b0100_0000;
    start_req(1'b1, 1'b0);
    do_walk(1'b1, 1, 3, -1);
    chk("drop_done_flush", dflush_done, 1);
    chk("drop_done_clear", dclear_done, 1);
    step();
    chk("drop_idle_done", dclear_done, 0);
    chk("drop_idle_busy", busy, 0);

    // Reset asserted while line 4 is in writeback.
    dirty_mask = 8'b0001_0000;
    start_req(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pre_rst_idx_%0d", i), line_idx, i);
      step();
    end
    chk("pre_rst_scan4_inv", line_inv, 0);
    step();
    chk("pre_rst_wb_req", wb_req, 1);
    chk("pre_rst_wb_idx", line_idx, 4);
    nRST   = 1'b0;
    wb_ack = 1'b1;
    #1;
    chk("mid_rst_wb_req", wb_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_inv", line_inv, 0);
    chk("mid_rst_idx", line_idx, 0);
    dcache_flush = 1'b0;
    step();
    nRST = 1'b1;
    #1;
    start_req(1'b0, 1'b1);
    do_walk(1'b0, 0, -1, -1);
    check_done_held(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
